id_ex_stage: RTL

//  Decode-to-execute pipeline register that sits directly downstream of the register file.

---
 rtl/id_ex_stage.sv | 119 +++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: captures register-file operands and decoded fields,
// inserts a bubble on load-use hazards or EX flush, and counts stall cycles.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [DATA_W-1:0] id_pc4,
  output logic [4:0]        rf_read1,
  output logic [4:0]        rf_read2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  input  logic              id_regWrite,
  input  logic              id_memRead,
  input  logic              id_memWrite,
  input  logic              id_memToReg,
  input  logic              id_aluSrc,
  input  logic              id_regDst,
  input  logic [1:0]        id_aluOp,
  input  logic              ex_flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_wreg,
  output logic              ex_regWrite,
  output logic              ex_memRead,
  output logic              ex_memWrite,
  output logic              ex_memToReg,
  output logic              ex_aluSrc,
  output logic [1:0]        ex_aluOp,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        wreg;
    logic              regWrite;
    logic              memRead;
    logic              memWrite;
    logic              memToReg;
    logic              aluSrc;
    logic [1:0]        aluOp;
  } ex_t;

  ex_t ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q;

  // opcode bits are decoded upstream; only the register/immediate fields matter here
  logic unused_opcode;
  assign unused_opcode = &{1'b0, id_instr[31:26]};

  assign rf_read1 = id_instr[25:21];
  assign rf_read2 = id_instr[20:16];

  // $0 never carries a real load result, so a load into it cannot create a hazard
  assign stall = ex_q.valid & ex_q.memRead & (ex_q.rt != 5'd0) & id_valid & ~ex_flush
               & ((ex_q.rt == id_instr[25:21]) | (ex_q.rt == id_instr[20:16]));

  always_comb begin
    ex_d = '0;
    if (!(ex_flush || stall) && id_valid) begin
      ex_d.valid    = 1'b1;
      ex_d.pc4      = id_pc4;
      ex_d.rs_data  = rf_data1;
      ex_d.rt_data  = rf_data2;
      ex_d.imm      = {{(DATA_W-16){id_instr[15]}}, id_instr[15:0]};
      ex_d.rs       = id_instr[25:21];
      ex_d.rt       = id_instr[20:16];
      ex_d.wreg     = id_regDst ? id_instr[15:11] : id_instr[20:16];
      ex_d.regWrite = id_regWrite;
      ex_d.memRead  = id_memRead;
      ex_d.memWrite = id_memWrite;
      ex_d.memToReg = id_memToReg;
      ex_d.aluSrc   = id_aluSrc;
      ex_d.aluOp    = id_aluOp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  always_ff @(posedge clk) begin
    if (rst)                                 cnt_q <= '0;
    else if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign ex_valid    = ex_q.valid;
  assign ex_pc4      = ex_q.pc4;
  assign ex_rs_data  = ex_q.rs_data;
  assign ex_rt_data  = ex_q.rt_data;
  assign ex_imm      = ex_q.imm;
  assign ex_rs       = ex_q.rs;
  assign ex_rt       = ex_q.rt;
  assign ex_wreg     = ex_q.wreg;
  assign ex_regWrite = ex_q.regWrite;
  assign ex_memRead  = ex_q.memRead;
  assign ex_memWrite = ex_q.memWrite;
  assign ex_memToReg = ex_q.memToReg;
  assign ex_aluSrc   = ex_q.aluSrc;
  assign ex_aluOp    = ex_q.aluOp;
  assign stall_cnt   = cnt_q;

endmodule
